// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, bank state type and bit-reversal helper
package fft_pkg;
   localparam int FFT_N        = 1024;
   localparam int FFT_ADDR_W   = 10;
   localparam int FFT_DATA_W   = 16;
   localparam int BITREV_MAX_W = 16;

   typedef enum logic [1:0] {BANK_FREE, BANK_FULL, BANK_INUSE} bank_state_t;

   // Reverses the low w bits of k; callers must keep bits at and above w clear.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] k,
                                                      input int w);
      logic [BITREV_MAX_W-1:0] r;
      r = {<<{k}};
      return r >> (BITREV_MAX_W - w);
   endfunction
endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port RAM, one write port and one registered read port
module sample_ram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic              Clk,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0] RdData
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge Clk) begin
      if (WrEn)
         mem[WrAddr] <= WrData;
      RdData <= mem[RdAddr];
   end
endmodule

// File: rtl/fft_sample_loader.sv
// rtl/fft_sample_loader.sv - ping-pong sample capture in bit-reversed order for the FFT core
module fft_sample_loader
   import fft_pkg::*;
#(
   parameter int N      = FFT_N,
   parameter int ADDR_W = FFT_ADDR_W,
   parameter int DATA_W = FFT_DATA_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] SampleIn,
   input  logic              SampleValid,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0] RdData_re,
   output logic [DATA_W-1:0] RdData_im,
   output logic              Start,
   input  logic              FftDone,
   output logic              Overrun,
   output logic [15:0]       FrameCount
);
   bank_state_t       st [2];
   bank_state_t       st_n [2];
   logic              cap_bank, cap_bank_n;
   logic              rd_bank, rd_bank_n;
   logic              start_bank, start_bank_n;
   logic              start_n, ovr_n, wr_en, rd_valid;
   logic [ADDR_W-1:0] cnt, cnt_n;
   logic [ADDR_W:0]   wr_addr, rd_addr;
   logic [DATA_W-1:0] ram_q;

   always_comb begin
      st_n[0]      = st[0];
      st_n[1]      = st[1];
      cap_bank_n   = cap_bank;
      rd_bank_n    = rd_bank;
      cnt_n        = cnt;
      ovr_n        = Overrun;
      wr_en        = 1'b0;
      start_n      = 1'b0;
      start_bank_n = start_bank;

      if (Start) begin
         st_n[start_bank] = BANK_INUSE;
         rd_bank_n        = start_bank;
      end
      if (FftDone && st[rd_bank] == BANK_INUSE)
         st_n[rd_bank] = BANK_FREE;

      if (SampleValid) begin
         if (st[cap_bank] == BANK_FREE) begin
            wr_en = 1'b1;
            if (cnt == ADDR_W'(N-1)) begin
               st_n[cap_bank] = BANK_FULL;
               cap_bank_n     = ~cap_bank;
               cnt_n          = '0;
            end else begin
               cnt_n = cnt + ADDR_W'(1);
            end
         end else begin
            ovr_n = 1'b1;
         end
      end

      // Start is decided on next-state so it lands in the first cycle a bank sits FULL.
      // With both FULL, the bank under the capture pointer is the older one.
      if (st_n[0] != BANK_INUSE && st_n[1] != BANK_INUSE) begin
         if (st_n[cap_bank_n] == BANK_FULL) begin
            start_n      = 1'b1;
            start_bank_n = cap_bank_n;
         end else if (st_n[~cap_bank_n] == BANK_FULL) begin
            start_n      = 1'b1;
            start_bank_n = ~cap_bank_n;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         st[0]      <= BANK_FREE;
         st[1]      <= BANK_FREE;
         cap_bank   <= 1'b0;
         rd_bank    <= 1'b0;
         start_bank <= 1'b0;
         cnt        <= '0;
         Start      <= 1'b0;
         Overrun    <= 1'b0;
         FrameCount <= '0;
         rd_valid   <= 1'b0;
      end else begin
         st[0]      <= st_n[0];
         st[1]      <= st_n[1];
         cap_bank   <= cap_bank_n;
         rd_bank    <= rd_bank_n;
         start_bank <= start_bank_n;
         cnt        <= cnt_n;
         Start      <= start_n;
         Overrun    <= ovr_n;
         if (start_n)
            FrameCount <= FrameCount + 16'd1;
         rd_valid   <= (st[0] == BANK_INUSE) || (st[1] == BANK_INUSE);
      end
   end

   assign wr_addr = {cap_bank, ADDR_W'(bitrev(BITREV_MAX_W'(cnt), ADDR_W))};
   assign rd_addr = {rd_bank, RdAddr};

   sample_ram #(.ADDR_W(ADDR_W + 1), .DATA_W(DATA_W)) u_ram (
      .Clk    (Clk),
      .WrEn   (wr_en),
      .WrAddr (wr_addr),
      .WrData (SampleIn),
      .RdAddr (rd_addr),
      .RdData (ram_q)
   );

   assign RdData_re = rd_valid ? ram_q : '0;
   assign RdData_im = '0;
endmodule

// File: tb/tb_fft_sample_loader.sv
// tb/tb_fft_sample_loader.sv - frame-level reference model with directed and random stimulus
module tb_fft_sample_loader;
   localparam int N  = 1024;
   localparam int AW = 10;
   localparam int DW = 16;

   logic          Clk = 1'b0;
   logic          Reset, SampleValid, FftDone, Start, Overrun;
   logic [DW-1:0] SampleIn, RdData_re, RdData_im;
   logic [AW-1:0] RdAddr;
   logic [15:0]   FrameCount;
   int            n_checks = 0;
   int            n_fail = 0;

   always #5 Clk = ~Clk;

   fft_sample_loader #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .SampleIn   (SampleIn),
      .SampleValid(SampleValid),
      .RdAddr     (RdAddr),
      .RdData_re  (RdData_re),
      .RdData_im  (RdData_im),
      .Start      (Start),
      .FftDone    (FftDone),
      .Overrun    (Overrun),
      .FrameCount (FrameCount)
   );

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int tb_rev(input int a);
      int r = 0;
      for (int i = 0; i < AW; i++)
         if (((a >> i) & 1) != 0) r += 1 << (AW - 1 - i);
      return r;
   endfunction

   // Frame f lands in the buffer vacated by frame f-2, so it may capture once f-2 is released.
   bit                   armed = 0;
   bit                   m_start, m_ovr, m_inuse;
   int                   m_fc, m_released, m_cur_frame, m_cnt;
   logic signed [DW-1:0] m_rd;
   logic signed [DW-1:0] m_buf [N];
   logic signed [DW-1:0] m_frame [N];
   logic signed [DW-1:0] m_q [$];

   always @(posedge Clk) begin
      int   rel_old;
      logic done_ok;
      if (Reset) begin
         armed = 1; m_start = 0; m_ovr = 0; m_inuse = 0; m_fc = 0;
         m_released = 0; m_cur_frame = 0; m_cnt = 0; m_rd = '0;
         m_q.delete();
      end else if (armed) begin
         rel_old = m_released;
         m_rd    = m_inuse ? m_frame[tb_rev(int'(RdAddr))] : '0;
         done_ok = FftDone && m_inuse;
         if (m_start) m_inuse = 1;
         if (done_ok) begin
            m_inuse = 0;
            m_released++;
         end
         if (SampleValid) begin
            if (m_cur_frame < rel_old + 2) begin
               m_buf[m_cnt] = $signed(SampleIn);
               m_cnt++;
               if (m_cnt == N) begin
                  for (int i = 0; i < N; i++) m_q.push_back(m_buf[i]);
                  m_cnt = 0;
                  m_cur_frame++;
               end
            end else begin
               m_ovr = 1;
            end
         end
         m_start = 0;
         if (!m_inuse && m_q.size() >= N) begin
            m_start = 1;
            m_fc    = (m_fc + 1) % 65536;
            for (int i = 0; i < N; i++) m_frame[i] = m_q.pop_front();
         end
      end
   end

   always @(negedge Clk) begin
      if (armed) begin
         chk("start", Start, m_start);
         chk("overrun", Overrun, m_ovr);
         chk("frame_count", FrameCount, m_fc);
         chk("rd_re", $signed(RdData_re), m_rd);
         chk("rd_im", RdData_im, 0);
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] v);
      SampleValid = 1'b1;
      SampleIn    = v;
      RdAddr      = AW'($urandom);
      step();
      SampleValid = 1'b0;
   endtask

   task automatic fft_done();
      FftDone = 1'b1;
      step();
      FftDone = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   task automatic rd_lit(input int a, input int e);
      RdAddr = AW'(a);
      step();
      chk("rd_literal", $signed(RdData_re), e);
   endtask

   initial begin
      int busy, timer;
      Reset = 1'b1; SampleValid = 1'b0; SampleIn = '0; FftDone = 1'b0; RdAddr = '0;
      step(); step();
      Reset = 1'b0;
      chk("reset_start", Start, 0);
      chk("reset_overrun", Overrun, 0);
      chk("reset_fc", FrameCount, 0);
      chk("reset_rd", RdData_re, 0);

      // ramp frame
      for (int k = 0; k < N; k++) begin
         if (k == N - 1) chk("ramp_no_early_start", Start, 0);
         send(DW'(k));
      end
      chk("ramp_start", Start, 1);
      chk("ramp_fc", FrameCount, 1);
      step();
      chk("ramp_start_once", Start, 0);
      rd_lit(1, 512);
      rd_lit(2, 256);
      rd_lit(1023, 1023);
      chk("ramp_im", RdData_im, 0);
      for (int i = 0; i < 20; i++) begin
         RdAddr = AW'($urandom);
         step();
      end
      fft_done();

      // full-scale extremes
      send(16'h8000);
      send(16'h7fff);
      for (int k = 2; k < N; k++) send(DW'($urandom));
      step();
      rd_lit(0, -32768);
      rd_lit(512, 32767);
      fft_done();

      // two frames with FftDone withheld
      do_reset();
      for (int k = 0; k < 2 * N; k++) send(DW'($urandom));
      step(); step();
      chk("two_full_no_start", Start, 0);
      chk("two_full_no_ovr", Overrun, 0);
      chk("two_full_fc", FrameCount, 1);
      send(DW'($urandom));
      chk("overrun_set", Overrun, 1);
      fft_done();
      chk("start_after_done", Start, 1);
      chk("fc_after_done", FrameCount, 2);
      step();
      chk("overrun_sticky", Overrun, 1);

      // final sample coinciding with FftDone
      do_reset();
      for (int k = 0; k < N; k++) send(DW'($urandom));
      step();
      for (int k = 0; k < N; k++) begin
         if (k == N - 1) begin
            chk("coincide_pre", Start, 0);
            FftDone = 1'b1;
         end
         send(DW'($urandom));
      end
      FftDone = 1'b0;
      chk("coincide_start", Start, 1);
      chk("coincide_no_ovr", Overrun, 0);
      chk("coincide_fc", FrameCount, 2);

      // reset in the middle of a partial frame
      do_reset();
      for (int k = 0; k < 500; k++) send(DW'($urandom));
      do_reset();
      chk("abort_start", Start, 0);
      chk("abort_ovr", Overrun, 0);
      chk("abort_fc", FrameCount, 0);
      for (int k = 0; k < N - 1; k++) send(DW'($urandom));
      chk("abort_partial_no_start", Start, 0);
      send(DW'($urandom));
      chk("abort_full_start", Start, 1);

      // sparse SampleValid
      step();
      fft_done();
      for (int k = 0; k < N; k++) begin
         step(); step();
         send(DW'($urandom));
      end
      chk("sparse_start", Start, 1);
      chk("sparse_no_ovr", Overrun, 0);
      step();
      fft_done();

      // random traffic with an emulated FFT and spurious FftDone pulses
      busy = 0;
      timer = 0;
      for (int c = 0; c < 8000; c++) begin
         Reset = (c == 4000);
         if (c == 4000) busy = 0;
         SampleValid = ($urandom_range(0, 9) < 7);
         SampleIn    = DW'($urandom);
         RdAddr      = AW'($urandom);
         FftDone     = 1'b0;
         if (busy != 0) begin
            if (timer == 0) begin
               FftDone = 1'b1;
               busy = 0;
            end else begin
               timer--;
            end
         end else if ($urandom_range(0, 199) == 0) begin
            FftDone = 1'b1;
         end
         step();
         if (Start && busy == 0) begin
            busy  = 1;
            timer = $urandom_range(50, 1500);
         end
      end
      Reset = 1'b0; SampleValid = 1'b0; FftDone = 1'b0;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
